// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite SRAM responder: response codes,
// FSM state encodings and the byte-strobe merge helper.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Widest data path the merge helper handles; narrower buses are zero-extended.
  localparam int MERGE_W = 64;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  function automatic logic [MERGE_W-1:0] strb_merge(
    input logic [MERGE_W-1:0]   old_val,
    input logic [MERGE_W-1:0]   new_val,
    input logic [MERGE_W/8-1:0] strb
  );
    logic [MERGE_W-1:0] merged;
    merged = old_val;
    for (int i = 0; i < MERGE_W/8; i++) begin
      if (strb[i]) begin
        merged[8*i +: 8] = new_val[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_val[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/axil_sram_slave.sv
// AXI4-Lite memory-side responder over a word-organised SRAM array, with
// independent read/write channels and parameterised response latency.
module axil_sram_slave
  import axil_pkg::*;
#(
  parameter int                ADDR_W = 32,
  parameter int                DATA_W = 32,
  parameter int                DEPTH  = 4096,
  parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000,
  parameter int                RD_LAT = 1,
  parameter int                WR_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready
);

  localparam int                STRB_W  = DATA_W/8;
  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] SPAN    = ADDR_W'(4*DEPTH);
  // The extra count models the registered array read: rvalid lands RD_LAT+1 edges after AR.
  localparam logic [3:0]        RD_LOAD = 4'(RD_LAT);
  localparam logic [3:0]        WR_LOAD = 4'(WR_LAT-1);

  function automatic logic addr_hit(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE;
    return off < SPAN;
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE;
    return off[IDX_W+1:2];
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  rd_state_e         r_state_q, r_state_d;
  logic [3:0]        r_cnt_q, r_cnt_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  wr_state_e         w_state_q, w_state_d;
  logic [3:0]        w_cnt_q, w_cnt_d;
  logic              aw_cap_q, aw_cap_d;
  logic              w_cap_q, w_cap_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0] w_strb_q, w_strb_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              wr_commit;
  logic [DATA_W-1:0] wr_merged;

  assign arready = (r_state_q == R_IDLE) & ~rst;
  assign rvalid  = (r_state_q == R_RESP);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  assign awready = (w_state_q == W_IDLE) & ~aw_cap_q & ~rst;
  assign wready  = (w_state_q == W_IDLE) & ~w_cap_q & ~rst;
  assign bvalid  = (w_state_q == W_RESP);
  assign bresp   = bresp_q;

  assign wr_merged = DATA_W'(strb_merge(MERGE_W'(mem[addr_idx(w_addr_q)]),
                                        MERGE_W'(w_data_q),
                                        (MERGE_W/8)'(w_strb_q)));

  // Read channel next-state: accept one AR, count down, then present the response.
  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    r_addr_d  = r_addr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (arvalid) begin
          r_addr_d  = araddr;
          r_cnt_d   = RD_LOAD;
          r_state_d = R_WAIT;
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_WAIT: begin
        if (r_cnt_q == 4'd0) begin
          if (addr_hit(r_addr_q)) begin
            rdata_d = mem[addr_idx(r_addr_q)];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = {DATA_W{1'b0}};
            rresp_d = RESP_SLVERR;
          end
          r_state_d = R_RESP;
        end else begin
          r_cnt_d = r_cnt_q - 4'd1;
        end
      end
      R_RESP: begin
        if (rready) begin
          r_state_d = R_IDLE;
        end else begin
          r_state_d = R_RESP;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read channel registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= 4'd0;
      r_addr_q  <= {ADDR_W{1'b0}};
      rdata_q   <= {DATA_W{1'b0}};
      rresp_q   <= 2'b00;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      r_addr_q  <= r_addr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Write channel next-state: capture AW and W independently, wait, commit, respond.
  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    aw_cap_d  = aw_cap_q;
    w_cap_d   = w_cap_q;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bresp_d   = bresp_q;
    wr_commit = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (awvalid && !aw_cap_q) begin
          aw_cap_d = 1'b1;
          w_addr_d = awaddr;
        end else begin
          aw_cap_d = aw_cap_q;
        end
        if (wvalid && !w_cap_q) begin
          w_cap_d  = 1'b1;
          w_data_d = wdata;
          w_strb_d = wstrb;
        end else begin
          w_cap_d = w_cap_q;
        end
        if (aw_cap_d && w_cap_d) begin
          w_cnt_d   = WR_LOAD;
          w_state_d = W_WAIT;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_WAIT: begin
        if (w_cnt_q == 4'd0) begin
          if (addr_hit(w_addr_q)) begin
            wr_commit = ~rst;
            bresp_d   = RESP_OKAY;
          end else begin
            wr_commit = 1'b0;
            bresp_d   = RESP_SLVERR;
          end
          w_state_d = W_RESP;
        end else begin
          w_cnt_d = w_cnt_q - 4'd1;
        end
      end
      W_RESP: begin
        if (bready) begin
          aw_cap_d  = 1'b0;
          w_cap_d   = 1'b0;
          w_state_d = W_IDLE;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write channel registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_cnt_q   <= 4'd0;
      aw_cap_q  <= 1'b0;
      w_cap_q   <= 1'b0;
      w_addr_q  <= {ADDR_W{1'b0}};
      w_data_q  <= {DATA_W{1'b0}};
      w_strb_q  <= {STRB_W{1'b0}};
      bresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      aw_cap_q  <= aw_cap_d;
      w_cap_q   <= w_cap_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bresp_q   <= bresp_d;
    end
  end

  // Array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      mem[addr_idx(w_addr_q)] <= wr_merged;
    end
  end

endmodule

// File: tb/tb_axil_sram_slave.sv
// Randomised scoreboard bench for axil_sram_slave with a word-level memory model.
module tb_axil_sram_slave;

  localparam int          AW     = 32;
  localparam int          DW     = 32;
  localparam int          DEPTH  = 4096;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          RD_LAT = 3;
  localparam int          WR_LAT = 2;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] araddr = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [AW-1:0] awaddr = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;

  axil_sram_slave #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .BASE(BASE),
    .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model: word-indexed memory
  logic [31:0] mdl [int];

  function automatic bit m_in(input logic [31:0] a);
    longint u;
    u = longint'({32'd0, a});
    return (u >= longint'({32'd0, BASE})) && (u < longint'({32'd0, BASE}) + 4 * DEPTH);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((longint'({32'd0, a}) - longint'({32'd0, BASE})) / 4);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!m_in(a)) return 32'h0;
    if (!mdl.exists(m_idx(a))) return 32'hxxxx_xxxx;
    return mdl[m_idx(a)];
  endfunction

  function automatic void m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    if (m_in(a)) begin
      w = m_read(a);
      for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      mdl[m_idx(a)] = w;
    end
  endfunction

  // Scoreboard queues
  logic [33:0] rd_q[$];
  logic [1:0]  b_q[$];
  int          ar_edge_q[$];
  int          both_edge_q[$];

  logic rv_prev = 1'b0;
  logic bv_prev = 1'b0;

  // Monitor: latency on rising valid, payload on each handshake
  always @(negedge clk) begin
    if (rst) begin
      rv_prev <= 1'b0;
      bv_prev <= 1'b0;
    end else begin
      if (rvalid && !rv_prev) begin
        if (ar_edge_q.size() > 0) chk("rd_latency", 64'(cyc - ar_edge_q.pop_front()), 64'(RD_LAT + 1));
        else fail_now("rvalid_unexpected");
      end
      if (bvalid && !bv_prev) begin
        if (both_edge_q.size() > 0) chk("wr_latency", 64'(cyc - both_edge_q.pop_front()), 64'(WR_LAT));
        else fail_now("bvalid_unexpected");
      end
      if (rvalid && rready) begin
        if (rd_q.size() > 0) begin
          logic [33:0] e;
          e = rd_q.pop_front();
          chk("rdata", 64'(rdata), 64'(e[31:0]));
          chk("rresp", 64'(rresp), 64'(e[33:32]));
        end else fail_now("r_handshake_unexpected");
      end
      if (bvalid && bready) begin
        if (b_q.size() > 0) chk("bresp", 64'(bresp), 64'(b_q.pop_front()));
        else fail_now("b_handshake_unexpected");
      end
      rv_prev <= rvalid;
      bv_prev <= bvalid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // hold < 0: rready high in advance; otherwise rready low for hold valid cycles
  task automatic do_read(input logic [31:0] addr, input int hold);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    int n;
    exp_d = m_read(addr);
    exp_r = m_in(addr) ? OKAY : SLVERR;
    rready  = (hold < 0);
    araddr  = addr;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin tick(); n++; end
    if (!arready) begin fail_now("ar_timeout"); arvalid = 1'b0; return; end
    tick();
    arvalid = 1'b0;
    araddr  = $urandom;
    rd_q.push_back({exp_r, exp_d});
    ar_edge_q.push_back(cyc);
    n = 0;
    while (!rvalid && n < 40) begin tick(); n++; end
    if (!rvalid) begin fail_now("rvalid_timeout"); rready = 1'b0; return; end
    for (int i = 0; i < hold; i++) begin
      chk("rvalid_held", 64'(rvalid), 64'd1);
      chk("rdata_held", 64'(rdata), 64'(exp_d));
      chk("arready_busy", 64'(arready), 64'd0);
      tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("rvalid_done", 64'(rvalid), 64'd0);
    chk("arready_back", 64'(arready), 64'd1);
  endtask

  // lead > 0: W first by lead cycles; lead < 0: AW first; bhold < 0: bready early
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int lead, input int bhold);
    int t, n, aw_start, w_start;
    bit aw_done, w_done, aw_f, w_f;
    aw_start = (lead < 0) ? 0 : lead;
    w_start  = (lead < 0) ? -lead : 0;
    aw_done = 1'b0;
    w_done  = 1'b0;
    bready  = (bhold < 0);
    t = 0;
    while (!(aw_done && w_done) && t < 40) begin
      if (t >= aw_start && !aw_done) begin awaddr = addr; awvalid = 1'b1; end
      if (t >= w_start && !w_done) begin wdata = data; wstrb = strb; wvalid = 1'b1; end
      if (w_done && !aw_done) chk("wready_low_after_w", 64'(wready), 64'd0);
      if (aw_done && !w_done) chk("awready_low_after_aw", 64'(awready), 64'd0);
      if (aw_done || w_done) chk("bvalid_early", 64'(bvalid), 64'd0);
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      tick();
      t++;
      if (aw_f) begin aw_done = 1'b1; awvalid = 1'b0; end
      if (w_f)  begin w_done  = 1'b1; wvalid  = 1'b0; end
    end
    if (!(aw_done && w_done)) begin
      fail_now("aw_w_timeout");
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
      return;
    end
    both_edge_q.push_back(cyc);
    b_q.push_back(m_in(addr) ? OKAY : SLVERR);
    m_write(addr, data, strb);
    n = 0;
    while (!bvalid && n < 40) begin tick(); n++; end
    if (!bvalid) begin fail_now("bvalid_timeout"); bready = 1'b0; return; end
    for (int i = 0; i < bhold; i++) begin
      chk("bvalid_held", 64'(bvalid), 64'd1);
      tick();
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bvalid_done", 64'(bvalid), 64'd0);
  endtask

  initial begin
    logic [31:0] a, old;
    logic [31:0] oor [4];
    oor[0] = 32'h0000_0000;
    oor[1] = BASE - 32'd4;
    oor[2] = BASE + 32'(4 * DEPTH);
    oor[3] = 32'hFFFF_FFFC;

    repeat (3) tick();
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_rresp", 64'(rresp), 64'd0);
    chk("rst_bresp", 64'(bresp), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_arready", 64'(arready), 64'd1);
    chk("post_rst_awready", 64'(awready), 64'd1);
    chk("post_rst_wready", 64'(wready), 64'd1);

    for (int i = 0; i < 16; i++) do_write(BASE + 32'(4 * i), $urandom, 4'hF, 0, -1);
    do_write(BASE + 32'(4 * (DEPTH - 1)), $urandom, 4'hF, 0, -1);

    do_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, -1);
    do_read(BASE + 32'h10, -1);

    do_write(BASE + 32'h14, 32'h1122_3344, 4'hF, 0, -1);
    do_write(BASE + 32'h14, 32'hAABB_CCDD, 4'b0101, 0, -1);
    do_read(BASE + 32'h14, -1);
    chk("strobe_model", 64'(m_read(BASE + 32'h14)), 64'h11BB_33DD);

    do_write(BASE + 32'h18, 32'h0BAD_F00D, 4'hF, 3, -1);
    do_read(BASE + 32'h18, 0);
    do_write(BASE + 32'h1C, 32'hC0FF_EE00, 4'hF, -2, 1);
    do_read(BASE + 32'h1C, -1);

    do_read(BASE + 32'h10, 5);

    do_read(32'h0000_0000, 2);
    do_write(BASE + 32'h4000, 32'h5555_AAAA, 4'hF, 0, -1);
    do_read(BASE, -1);
    do_read(BASE + 32'(4 * (DEPTH - 1)), -1);

    do_write(BASE + 32'h20, 32'hFFFF_FFFF, 4'h0, 0, 2);
    do_read(BASE + 32'h20, -1);

    // Read and write of one word committing on the same edge
    a = BASE + 32'h24;
    old = m_read(a);
    rready = 1'b1;
    bready = 1'b1;
    araddr = a; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    rd_q.push_back({OKAY, old});
    ar_edge_q.push_back(cyc);
    tick();
    awaddr = a; wdata = ~old; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    both_edge_q.push_back(cyc);
    b_q.push_back(OKAY);
    m_write(a, ~old, 4'hF);
    repeat (8) tick();
    rready = 1'b0;
    bready = 1'b0;
    do_read(a, -1);

    // Reset while both channels are waiting
    a = BASE + 32'h28;
    araddr = a; awaddr = a; wdata = ~m_read(a); wstrb = 4'hF;
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_rvalid", 64'(rvalid), 64'd0);
    chk("midrst_bvalid", 64'(bvalid), 64'd0);
    chk("midrst_arready", 64'(arready), 64'd0);
    chk("midrst_awready", 64'(awready), 64'd0);
    chk("midrst_wready", 64'(wready), 64'd0);
    chk("midrst_rdata", 64'(rdata), 64'd0);
    rst = 1'b0;
    #1;
    chk("postmid_arready", 64'(arready), 64'd1);
    chk("postmid_awready", 64'(awready), 64'd1);
    chk("postmid_wready", 64'(wready), 64'd1);
    repeat (4) tick();
    chk("midrst_no_bvalid", 64'(bvalid), 64'd0);
    do_read(a, -1);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) == 0) a = oor[$urandom_range(0, 3)];
      else a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 4) - 2, $urandom_range(0, 3) - 1);
      else
        do_read(a, $urandom_range(0, 4) - 1);
    end

    repeat (10) tick();
    chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
    chk("b_q_drained", 64'(b_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
